register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter SIZE, default 16: data width of each register.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; register count is 2**ADDR_W (16).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port write_enable, input, 1 bit: write strobe.
REQ-006 SHALL have port waddr, input, ADDR_W bits: write address.
REQ-007 SHALL have port data_in, input, SIZE bits: write data.
REQ-008 SHALL have port read_enable, input, 1 bit: read request for both read ports.
REQ-009 SHALL have ports raddr_a and raddr_b, inputs, ADDR_W bits each: read addresses.
REQ-010 SHALL have ports data_out_a and data_out_b, outputs, SIZE bits each: registered read data.
REQ-011 SHALL have port read_valid, output, 1 bit: data_out_a/b updated this cycle.
REQ-012 SHALL have port dump_start, input, 1 bit: request a sequential dump of all registers.
REQ-013 SHALL have port dump_busy, output, 1 bit: dump in progress.
REQ-014 SHALL have ports dump_addr (ADDR_W bits) and dump_data (SIZE bits), outputs: address and contents of the register currently being dumped.
REQ-015 SHALL have port dump_valid, output, 1 bit: dump_addr/dump_data valid this cycle.

Function
REQ-016 SHALL store 2**ADDR_W registers of SIZE bits; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-017 SHALL write data_in to register waddr on a rising clk edge while write_enable=1.
REQ-018 SHALL sample raddr_a/raddr_b when read_enable=1 at an edge and present the contents on data_out_a/b after that edge (1-cycle latency), with read_valid=1 for exactly that cycle.
REQ-019 SHALL hold data_out_a/b unchanged and drive read_valid=0 after any edge where read_enable=0.
REQ-020 SHALL bypass: if write_enable=1 and waddr equals a nonzero read address at the same edge, the corresponding data_out SHALL return data_in, not the old contents.
REQ-021 SHALL implement a dump FSM with states IDLE and DUMP.
REQ-022 In IDLE, dump_start=1 at an edge SHALL move to DUMP with dump_addr=0; otherwise remain in IDLE.
REQ-023 In DUMP, each cycle SHALL present dump_addr and dump_data=register[dump_addr] with dump_valid=1, then increment dump_addr.
REQ-024 After presenting address 2**ADDR_W-1, the FSM SHALL return to IDLE; dump_addr SHALL NOT wrap into a second pass.
REQ-025 A dump SHALL take exactly 2**ADDR_W cycles with dump_busy=1 throughout, and dump_busy=0 in IDLE.
REQ-026 dump_start SHALL be ignored while dump_busy=1.
REQ-027 The dump path SHALL be independent of the read ports; normal reads and writes SHALL proceed during a dump.
REQ-028 A write to the address being dumped at the same edge SHALL appear on dump_data (same bypass rule as REQ-020).

Reset
REQ-029 reset=1 SHALL immediately, without a clock edge, clear all registers, data_out_a/b, dump_addr and dump_data to 0, clear read_valid, dump_valid and dump_busy, and force IDLE.
REQ-030 reset asserted mid-dump SHALL abort the dump; after deassertion the block SHALL stay in IDLE until a new dump_start.

Verification
REQ-031 Write 0x1234 to R3, then read_enable with raddr_a=3, raddr_b=0 -> next cycle data_out_a=0x1234, data_out_b=0x0000, read_valid=1 for one cycle.
REQ-032 Write 0xBEEF to R0, then read R0 -> data_out_a=0x0000.
REQ-033 Same edge: write 0x00AA to R5 and read raddr_a=5 -> data_out_a=0x00AA (bypass).
REQ-034 Load Rn=n*0x0101, pulse dump_start -> 16 consecutive cycles with dump_valid=1, dump_addr 0..15, dump_data 0x0000, 0x0101, ..., 0x0F0F; then dump_busy=0.
REQ-035 Pulse dump_start again at dump_addr=7 -> ignored; dump ends after address 15 with no restart.
REQ-036 Assert reset at dump_addr=9 -> dump_busy=0, dump_valid=0, outputs 0 immediately; read of R3 after deassertion returns 0x0000.

Source files
------------

// File: rtl/register_file_if.sv
// Bus bundle for register_file: write port, dual read port and dump stream.
interface register_file_if #(
  parameter int SIZE   = 16,
  parameter int ADDR_W = 4
);
  logic              write_enable;
  logic [ADDR_W-1:0] waddr;
  logic [SIZE-1:0]   data_in;
  logic              read_enable;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [SIZE-1:0]   data_out_a;
  logic [SIZE-1:0]   data_out_b;
  logic              read_valid;
  logic              dump_start;
  logic              dump_busy;
  logic [ADDR_W-1:0] dump_addr;
  logic [SIZE-1:0]   dump_data;
  logic              dump_valid;

  // Requester side: drives writes, reads and dump requests.
  modport master (
    output write_enable, waddr, data_in, read_enable, raddr_a, raddr_b, dump_start,
    input  data_out_a, data_out_b, read_valid, dump_busy, dump_addr, dump_data, dump_valid
  );

  // Register file side.
  modport slave (
    input  write_enable, waddr, data_in, read_enable, raddr_a, raddr_b, dump_start,
    output data_out_a, data_out_b, read_valid, dump_busy, dump_addr, dump_data, dump_valid
  );
endinterface

// File: rtl/register_file.sv
// 2**ADDR_W x SIZE register file: R0 hardwired to zero, two registered read
// ports with write-through bypass, and a one-shot sequential dump engine.
module register_file #(
  parameter int SIZE   = 16,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {IDLE, DUMP} dump_state_e;

  logic [SIZE-1:0]   regs [NREG];
  logic [SIZE-1:0]   data_out_a_q, data_out_b_q;
  logic              read_valid_q;
  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [SIZE-1:0]   dump_data_q;
  logic              dump_load;

  // Read value seen at the coming edge: R0 is zero, a same-edge write wins.
  function automatic logic [SIZE-1:0] read_byp(input logic [ADDR_W-1:0] addr);
    if (addr == '0)
      return '0;
    else if (bus.write_enable && bus.waddr == addr)
      return bus.data_in;
    else
      return regs[addr];
  endfunction

  // Storage array; R0 is never written so it stays at its reset value of zero.
  // NOTE: the array is in the async reset because reset must clear every register; this keeps it out of block RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.write_enable && bus.waddr != '0) begin
      // NOTE: non-blocking so every reader in this edge sees the pre-edge contents.
      regs[bus.waddr] <= bus.data_in;
    end
  end

  // Read ports: capture on read_enable, otherwise hold data and drop read_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_a_q <= '0;
      data_out_b_q <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= bus.read_enable;
      if (bus.read_enable) begin
        data_out_a_q <= read_byp(bus.raddr_a);
        data_out_b_q <= read_byp(bus.raddr_b);
      end
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Dump FSM next state: single pass, start requests ignored while dumping.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.dump_start) state_d = DUMP;
      DUMP: if (dump_addr_q == LAST_ADDR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dump FSM outputs: which address to present after the coming edge.
  always_comb begin
    dump_load   = 1'b0;
    dump_addr_d = dump_addr_q;
    unique case (state_q)
      IDLE: if (bus.dump_start) begin
        dump_load   = 1'b1;
        dump_addr_d = '0;
      end
      DUMP: if (dump_addr_q != LAST_ADDR) begin
        dump_load   = 1'b1;
        dump_addr_d = dump_addr_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Dump address/data registers, loaded with the same bypass as the read ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else if (dump_load) begin
      dump_addr_q <= dump_addr_d;
      dump_data_q <= read_byp(dump_addr_d);
    end
  end

  assign bus.data_out_a = data_out_a_q;
  assign bus.data_out_b = data_out_b_q;
  assign bus.read_valid = read_valid_q;
  assign bus.dump_busy  = (state_q == DUMP);
  assign bus.dump_valid = (state_q == DUMP);
  assign bus.dump_addr  = dump_addr_q;
  assign bus.dump_data  = dump_data_q;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table for the read/write ports,
// hand-written sequences for dump, dump restart attempt and mid-dump reset.
module tb_register_file;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  register_file_if #(.SIZE(16), .ADDR_W(4)) bus ();
  register_file #(.SIZE(16), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] din;
    logic        re;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_rv;
  } vec_t;

  vec_t vecs [11];
  logic [15:0] mdl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_enable = 1'b0;
    bus.waddr        = '0;
    bus.data_in      = '0;
    bus.read_enable  = 1'b0;
    bus.raddr_a      = '0;
    bus.raddr_b      = '0;
    bus.dump_start   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout_a"}, 32'(bus.data_out_a), 32'h0);
    check({tag, "_dout_b"}, 32'(bus.data_out_b), 32'h0);
    check({tag, "_rvalid"}, 32'(bus.read_valid), 32'h0);
    check({tag, "_busy"},   32'(bus.dump_busy),  32'h0);
    check({tag, "_dvalid"}, 32'(bus.dump_valid), 32'h0);
    check({tag, "_daddr"},  32'(bus.dump_addr),  32'h0);
    check({tag, "_ddata"},  32'(bus.dump_data),  32'h0);
  endtask

  initial begin
    //               we  wa     din        re  ra     rb     exp_a      exp_b      rv
    vecs[0]  = '{1'b1, 4'd3,  16'h1234, 1'b0, 4'd0,  4'd0,  16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  4'd0,  16'h1234, 16'h0000, 1'b1};
    vecs[2]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd7,  4'd7,  16'h1234, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 4'd0,  16'hBEEF, 1'b0, 4'd0,  4'd0,  16'h1234, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd0,  4'd3,  16'h0000, 16'h1234, 1'b1};
    vecs[5]  = '{1'b1, 4'd5,  16'h00AA, 1'b1, 4'd5,  4'd5,  16'h00AA, 16'h00AA, 1'b1};
    vecs[6]  = '{1'b1, 4'd5,  16'h0055, 1'b1, 4'd5,  4'd3,  16'h0055, 16'h1234, 1'b1};
    vecs[7]  = '{1'b1, 4'd0,  16'hFFFF, 1'b1, 4'd0,  4'd0,  16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  4'd15, 16'h0055, 16'h0000, 1'b1};
    vecs[9]  = '{1'b1, 4'd15, 16'hABCD, 1'b0, 4'd1,  4'd1,  16'h0055, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd15, 4'd5,  16'hABCD, 16'h0055, 1'b1};

    idle_inputs();
    #2;
    check_all_zero("reset");
    step();
    reset = 1'b0;
    step();

    // Read/write vector table.
    for (int i = 0; i < 11; i++) begin
      bus.write_enable = vecs[i].we;
      bus.waddr        = vecs[i].waddr;
      bus.data_in      = vecs[i].din;
      bus.read_enable  = vecs[i].re;
      bus.raddr_a      = vecs[i].ra;
      bus.raddr_b      = vecs[i].rb;
      step();
      check($sformatf("vec%0d_dout_a", i), 32'(bus.data_out_a), 32'(vecs[i].exp_a));
      check($sformatf("vec%0d_dout_b", i), 32'(bus.data_out_b), 32'(vecs[i].exp_b));
      check($sformatf("vec%0d_rvalid", i), 32'(bus.read_valid), 32'(vecs[i].exp_rv));
    end
    idle_inputs();

    // Load Rn = n * 0x0101.
    mdl[0] = 16'h0000;
    for (int n = 1; n < 16; n++) begin
      mdl[n] = 16'(n * 16'h0101);
      bus.write_enable = 1'b1;
      bus.waddr        = 4'(n);
      bus.data_in      = mdl[n];
      step();
    end
    idle_inputs();
    step();
    check("pre_dump_busy", 32'(bus.dump_busy), 32'h0);

    // Full dump; restart pulse at address 7; write R5 while address 4 is shown
    // (bypass onto the dump stream); read R2 while dumping.
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("dump%0d_valid", i), 32'(bus.dump_valid), 32'h1);
      check($sformatf("dump%0d_busy", i),  32'(bus.dump_busy),  32'h1);
      check($sformatf("dump%0d_addr", i),  32'(bus.dump_addr),  32'(i));
      check($sformatf("dump%0d_data", i),  32'(bus.dump_data),  32'(mdl[i]));
      idle_inputs();
      if (i == 7) bus.dump_start = 1'b1;
      if (i == 2) begin
        bus.read_enable = 1'b1;
        bus.raddr_a     = 4'd2;
      end
      if (i == 4) begin
        bus.write_enable = 1'b1;
        bus.waddr        = 4'd5;
        bus.data_in      = 16'h7777;
        mdl[5]           = 16'h7777;
      end
      step();
      if (i == 2) begin
        check("read_during_dump_a", 32'(bus.data_out_a), 32'h0202);
        check("read_during_dump_rv", 32'(bus.read_valid), 32'h1);
      end
    end
    idle_inputs();
    check("dump_end_busy",  32'(bus.dump_busy),  32'h0);
    check("dump_end_valid", 32'(bus.dump_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("no_restart%0d_busy", k), 32'(bus.dump_busy), 32'h0);
    end

    // Reset in the middle of a dump.
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("mid_dump_addr", 32'(bus.dump_addr), 32'h9);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post_reset%0d_busy", k), 32'(bus.dump_busy), 32'h0);
    end
    bus.read_enable = 1'b1;
    bus.raddr_a     = 4'd3;
    bus.raddr_b     = 4'd15;
    step();
    idle_inputs();
    check("post_reset_r3",  32'(bus.data_out_a), 32'h0);
    check("post_reset_r15", 32'(bus.data_out_b), 32'h0);
    check("post_reset_rv",  32'(bus.read_valid), 32'h1);
    step();
    check("post_reset_rv_drop", 32'(bus.read_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
